sprite_anim_renderer: RTL and testbench
=======================================

Name: sprite_anim_renderer

Overview:
- Parametrised successor to the per-asset palette-ROM image examples: renders one animated, palette-indexed sprite into the VGA pixel stream.
- Sprite frames are stored back to back in one synchronous ROM.
- Supports a fullscreen-stretch mode and a positioned, power-of-two-scaled mode with transparency.
- Frame stepping is synchronised to the VGA frame; the block sits between the VGA controller (DrawX/DrawY/blank) and the top-level colour compositor.

Parameters:
- IMG_W, 110, sprite width in texels
- IMG_H, 86, sprite height in texels
- NUM_FRAMES, 4, animation frames stored consecutively in ROM
- FRAME_HOLD, 8, VGA frames each animation frame is displayed (>=1)
- FULLSCREEN, 0, 1 = stretch sprite to SCREEN_W x SCREEN_H and ignore pos/scale; 0 = positioned mode
- SCALE_SHIFT, 1, positioned mode: each texel drawn as 2^SCALE_SHIFT x 2^SCALE_SHIFT pixels
- SCREEN_W, 640, visible width
- SCREEN_H, 480, visible height
- IDX_W, 4, palette index width
- ADDR_W, 16, ROM address width (must hold NUM_FRAMES*IMG_W*IMG_H-1)
- TRANSPARENT_IDX, 0, palette index treated as transparent in positioned mode

Ports:
- vga_clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel x
- DrawY  in  10  current pixel y
- blank  in  1  1 = visible region (draw enabled)
- pos_x  in  10  sprite top-left x (positioned mode)
- pos_y  in  10  sprite top-left y
- anim_en  in  1  1 = advance animation
- anim_loop  in  1  1 = wrap to frame 0 after last frame; 0 = hold last frame
- anim_restart  in  1  request to return to frame 0
- rom_address  out  ADDR_W  ROM address, registered
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_address
- pal_index  out  IDX_W  palette lookup index (= rom_q)
- pal_red, pal_green, pal_blue  in  4 each  combinational palette result
- red, green, blue  out  4 each  pixel colour, registered
- sprite_hit  out  1  aligned with red/green/blue: sprite pixel is opaque and visible
- anim_frame  out  clog2(NUM_FRAMES)  currently displayed frame
- anim_done  out  1  1 while holding the last frame with anim_loop=0

Behaviour:
- Reset (sync, active-high): red/green/blue=0, sprite_hit=0, rom_address=0, anim_frame=0, hold counter=0, anim_done=0, restart latch=0, all pipeline valid/hit/blank bits cleared. Reset mid-line takes effect on the next edge; outputs are 0 for the following 3 cycles regardless of inputs.
- Pipeline latency: 3 vga_clk cycles from DrawX/DrawY/blank to red/green/blue/sprite_hit.
  - S1 registers rom_address plus in_box and blank delays.
  - S2 is the ROM read; rom_q is combinationally mapped to pal_index.
  - S3 registers the outputs.
- Address calculation:
  - Frame base = anim_frame*IMG_W*IMG_H.
  - FULLSCREEN=1: lx=(DrawX*IMG_W)/SCREEN_W and ly=(DrawY*IMG_H)/SCREEN_H, integer truncation; in_box=1 whenever DrawX<SCREEN_W and DrawY<SCREEN_H.
  - FULLSCREEN=0: in_box when pos_x <= DrawX < pos_x+(IMG_W<<SCALE_SHIFT), same for y. Comparisons use 11-bit unsigned arithmetic, so a sprite crossing the right/bottom edge is clipped and never wraps. lx=(DrawX-pos_x)>>SCALE_SHIFT, ly likewise.
  - rom_address = base + ly*IMG_W + lx when in_box; otherwise 0, with in_box=0 carried down the pipeline.
- Output (S3):
  - blank=0 (delayed): colour=0 and sprite_hit=0.
  - FULLSCREEN=1 and in_box: colour=palette; sprite_hit=1. Transparency is ignored in this mode.
  - FULLSCREEN=0 and in_box and pal_index != TRANSPARENT_IDX: colour=palette; sprite_hit=1.
  - All other cases: colour=0 and sprite_hit=0.
- Animation FSM, with states PLAY, HOLD_LAST:
  - frame_start is a one-cycle internal pulse when DrawX==0 and DrawY==0. anim_frame changes only on frame_start, so there is no mid-frame tearing.
  - anim_restart is latched on any cycle and consumed at the next frame_start: anim_frame=0, hold=0, state PLAY. Restart wins over advancement at the same frame_start.
  - PLAY with anim_en=1: hold increments each frame_start. When hold==FRAME_HOLD-1, set hold=0 and advance the frame. From the last frame, advance to 0 if anim_loop=1; otherwise stay on the last frame and enter HOLD_LAST.
  - anim_en=0: hold and anim_frame are frozen.
  - HOLD_LAST: anim_done=1. Leaving requires restart, or anim_loop becoming 1, which wraps to 0 on the next completed hold period.
  - anim_frame updates on the frame_start edge. The pixel at (0,0) already uses the new base.

Test Plan:
- Reset held 5 cycles with blank=1 and pixels streaming -> colour=0, sprite_hit=0, anim_frame=0; the first non-zero colour appears exactly 3 cycles after reset deasserts.
- FULLSCREEN=0, SCALE_SHIFT=1, pos=(100,50), anim_frame=0: DrawX=100/101 -> rom_address=0 for both; DrawX=102 -> 1; DrawY=52, DrawX=100 -> 110; DrawX=99 or 320 -> sprite_hit=0.
- FULLSCREEN=1: DrawX=639, DrawY=479 -> rom_address = 85*110 + 109 = 9459; colour is driven even when rom_q=TRANSPARENT_IDX.
- Positioned mode, rom_q=0 inside the box -> colour=0, sprite_hit=0; rom_q=5 -> palette[5] with sprite_hit=1; blank=0 forces 0 with a matching 3-cycle delay.
- FRAME_HOLD=2, NUM_FRAMES=4, anim_loop=1, anim_en=1: simulate 9 frame_starts -> anim_frame sequence 0,0,1,1,2,2,3,3,0. With anim_loop=0 -> holds at 3 with anim_done=1.
- Raise anim_restart mid-frame while anim_frame=2 -> no change until the next (0,0); then anim_frame=0, anim_done=0, and the base address for frame 0 is used at that same pixel.

Source files
------------

// File: rtl/sprite_anim_renderer.sv
// Animated palette-indexed sprite renderer between the VGA controller and the colour compositor.
// Latency: 3 vga_clk cycles from DrawX/DrawY/blank to red/green/blue/sprite_hit.
// Backpressure: none; consumes one pixel per cycle in raster order, never stalls.
module sprite_anim_renderer #(
  parameter int IMG_W           = 110,
  parameter int IMG_H           = 86,
  parameter int NUM_FRAMES      = 4,
  parameter int FRAME_HOLD      = 8,
  parameter int FULLSCREEN      = 0,
  parameter int SCALE_SHIFT     = 1,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int IDX_W           = 4,
  parameter int ADDR_W          = 16,
  parameter int TRANSPARENT_IDX = 0,
  localparam int FRAME_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic               anim_en,
  input  logic               anim_loop,
  input  logic               anim_restart,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pal_index,
  input  logic [3:0]         pal_red,
  input  logic [3:0]         pal_green,
  input  logic [3:0]         pal_blue,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               sprite_hit,
  output logic [FRAME_W-1:0] anim_frame,
  output logic               anim_done
);

  localparam int HOLD_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int FRAME_SZ = IMG_W * IMG_H;
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [IDX_W-1:0]   TRANS_IDX  = IDX_W'(TRANSPARENT_IDX);

  typedef enum logic {ST_PLAY, ST_HOLD_LAST} anim_state_t;

  anim_state_t        r_state, w_state_nxt;
  logic [FRAME_W-1:0] r_frame, w_frame_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
  logic               r_restart, w_restart_nxt;
  logic               w_frame_start, w_restart_req;

  // Pipeline registers
  logic [ADDR_W-1:0]  r_rom_address;
  logic               r_in_box1, r_blank1, r_in_box2, r_blank2;
  logic [3:0]         r_red, r_green, r_blue;
  logic               r_hit;

  // Address datapath (32-bit working width, cast down at the register)
  logic [10:0] w_dx, w_dy, w_px, w_py, w_xend, w_yend;
  logic        w_in_box_pos, w_in_box_fs, w_in_box, w_opaque;
  logic [31:0] w_lx_pos, w_ly_pos, w_lx_fs, w_ly_fs, w_lx, w_ly;
  logic [31:0] w_base, w_addr;

  assign w_frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign w_restart_req = r_restart | anim_restart;

  // Animation next-state: frame only moves on frame_start; a pending restart beats advancement
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_nxt   = r_frame;
    w_hold_nxt    = r_hold;
    w_restart_nxt = w_restart_req;
    if (w_frame_start) begin
      w_restart_nxt = 1'b0;
      if (w_restart_req) begin
        w_frame_nxt = '0;
        w_hold_nxt  = '0;
        w_state_nxt = ST_PLAY;
      end else if (anim_en) begin
        case (r_state)
          ST_PLAY: begin
            if (r_hold == HOLD_MAX) begin
              w_hold_nxt = '0;
              if (r_frame == LAST_FRAME) begin
                if (anim_loop) w_frame_nxt = '0;
                else           w_state_nxt = ST_HOLD_LAST;
              end else begin
                w_frame_nxt = r_frame + FRAME_W'(1);
              end
            end else begin
              w_hold_nxt = r_hold + HOLD_W'(1);
            end
          end
          ST_HOLD_LAST: begin
            // Parked on the last frame; only re-enabling loop lets a fresh hold period run out
            if (anim_loop) begin
              if (r_hold == HOLD_MAX) begin
                w_hold_nxt  = '0;
                w_frame_nxt = '0;
                w_state_nxt = ST_PLAY;
              end else begin
                w_hold_nxt = r_hold + HOLD_W'(1);
              end
            end
          end
          default: w_state_nxt = ST_PLAY;
        endcase
      end
    end
  end

  // Animation state register
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state   <= ST_PLAY;
      r_frame   <= '0;
      r_hold    <= '0;
      r_restart <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_frame   <= w_frame_nxt;
      r_hold    <= w_hold_nxt;
      r_restart <= w_restart_nxt;
    end
  end

  // Positioned mode: 11-bit compares so a sprite hanging off the right/bottom clips instead of wrapping
  assign w_dx   = {1'b0, DrawX};
  assign w_dy   = {1'b0, DrawY};
  assign w_px   = {1'b0, pos_x};
  assign w_py   = {1'b0, pos_y};
  assign w_xend = w_px + 11'(IMG_W << SCALE_SHIFT);
  assign w_yend = w_py + 11'(IMG_H << SCALE_SHIFT);
  assign w_in_box_pos = (w_dx >= w_px) && (w_dx < w_xend) && (w_dy >= w_py) && (w_dy < w_yend);
  assign w_lx_pos = 32'((w_dx - w_px) >> SCALE_SHIFT);
  assign w_ly_pos = 32'((w_dy - w_py) >> SCALE_SHIFT);

  // Fullscreen mode: stretch by exact truncating scale of screen to texel coordinates
  assign w_in_box_fs = ({22'd0, DrawX} < 32'(SCREEN_W)) && ({22'd0, DrawY} < 32'(SCREEN_H));
  assign w_lx_fs = ({22'd0, DrawX} * 32'(IMG_W)) / 32'(SCREEN_W);
  assign w_ly_fs = ({22'd0, DrawY} * 32'(IMG_H)) / 32'(SCREEN_H);

  assign w_in_box = (FULLSCREEN != 0) ? w_in_box_fs : w_in_box_pos;
  assign w_lx     = (FULLSCREEN != 0) ? w_lx_fs : w_lx_pos;
  assign w_ly     = (FULLSCREEN != 0) ? w_ly_fs : w_ly_pos;

  // Base follows the next frame so the (0,0) pixel already reads the newly selected frame
  assign w_base = 32'(w_frame_nxt) * 32'(FRAME_SZ);
  assign w_addr = w_base + w_ly * 32'(IMG_W) + w_lx;

  // S1/S2: register ROM address and carry in_box/blank alongside the ROM read
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_rom_address <= '0;
      r_in_box1     <= 1'b0;
      r_blank1      <= 1'b0;
      r_in_box2     <= 1'b0;
      r_blank2      <= 1'b0;
    end else begin
      r_rom_address <= w_in_box ? ADDR_W'(w_addr) : '0;
      r_in_box1     <= w_in_box;
      r_blank1      <= blank;
      r_in_box2     <= r_in_box1;
      r_blank2      <= r_blank1;
    end
  end

  // Transparency applies only in positioned mode
  assign w_opaque = r_in_box2 && ((FULLSCREEN != 0) || (rom_q != TRANS_IDX));

  // S3: register colour, forced to black outside the visible region or sprite
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_red   <= 4'd0;
      r_green <= 4'd0;
      r_blue  <= 4'd0;
      r_hit   <= 1'b0;
    end else if (r_blank2 && w_opaque) begin
      r_red   <= pal_red;
      r_green <= pal_green;
      r_blue  <= pal_blue;
      r_hit   <= 1'b1;
    end else begin
      r_red   <= 4'd0;
      r_green <= 4'd0;
      r_blue  <= 4'd0;
      r_hit   <= 1'b0;
    end
  end

  assign rom_address = r_rom_address;
  assign pal_index   = rom_q;
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign sprite_hit  = r_hit;
  assign anim_frame  = r_frame;
  assign anim_done   = (r_state == ST_HOLD_LAST);

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: positioned and fullscreen instances share one stimulus stream.
// Expected values come from a timeline-based animation model and direct pixel arithmetic.
// Inputs driven on the falling edge; outputs compared 1 time unit after each rising edge.
module tb_sprite_anim_renderer;

  localparam int IW  = 110;
  localparam int IH  = 86;
  localparam int NF  = 4;
  localparam int FH  = 2;
  localparam int SS  = 1;
  localparam int FSZ = IW * IH;

  typedef struct packed {
    logic        hit;
    logic [11:0] rgb;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [9:0] draw_x, draw_y, pos_x, pos_y;
  logic       blank, anim_en, anim_loop, anim_restart;

  logic [15:0] p_addr, f_addr;
  logic [3:0]  p_q, f_q, p_idx, f_idx;
  logic [3:0]  p_pr, p_pg, p_pb, f_pr, f_pg, f_pb;
  logic [3:0]  p_r, p_g, p_b, f_r, f_g, f_b;
  logic        p_hit, f_hit, p_done, f_done;
  logic [1:0]  p_frame, f_frame;

  function automatic logic [3:0] rom_fn(input int a);
    int h;
    h = (a * 37) ^ (a >>> 4);
    return h[3:0];
  endfunction

  function automatic logic [11:0] pal(input logic [3:0] i);
    return {i ^ 4'h5, i + 4'd1, ~i};
  endfunction

  assign {p_pr, p_pg, p_pb} = pal(p_idx);
  assign {f_pr, f_pg, f_pb} = pal(f_idx);

  always @(posedge clk) begin
    p_q <= rom_fn(int'(p_addr));
    f_q <= rom_fn(int'(f_addr));
  end

  sprite_anim_renderer #(.FRAME_HOLD(FH), .NUM_FRAMES(NF), .FULLSCREEN(0), .SCALE_SHIFT(SS)) u_pos (
    .vga_clk(clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .anim_en(anim_en), .anim_loop(anim_loop),
    .anim_restart(anim_restart), .rom_address(p_addr), .rom_q(p_q), .pal_index(p_idx),
    .pal_red(p_pr), .pal_green(p_pg), .pal_blue(p_pb), .red(p_r), .green(p_g), .blue(p_b),
    .sprite_hit(p_hit), .anim_frame(p_frame), .anim_done(p_done));

  sprite_anim_renderer #(.FRAME_HOLD(FH), .NUM_FRAMES(NF), .FULLSCREEN(1)) u_fs (
    .vga_clk(clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .anim_en(anim_en), .anim_loop(anim_loop),
    .anim_restart(anim_restart), .rom_address(f_addr), .rom_q(f_q), .pal_index(f_idx),
    .pal_red(f_pr), .pal_green(f_pg), .pal_blue(f_pb), .red(f_r), .green(f_g), .blue(f_b),
    .sprite_hit(f_hit), .anim_frame(f_frame), .anim_done(f_done));

  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;

  // Model state: position on a cyclic timeline of NF*FH enabled frame_starts
  int   m_t = 0;
  bit   m_done = 1'b0;
  bit   m_pend = 1'b0;
  int   m_px = 100, m_py = 50;
  bit   m_en = 1'b1, m_loop = 1'b1, m_rr = 1'b0;

  int   e_p_addr = 0, e_f_addr = 0, e_frame = 0;
  bit   e_done = 1'b0;
  pix_t qp[$];
  pix_t qf[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int addr_pos(input int x, input int y, input int px, input int py,
                                  input int fr, output bit inb);
    inb = (x >= px) && (x < px + (IW << SS)) && (y >= py) && (y < py + (IH << SS));
    return inb ? fr * FSZ + ((y - py) >> SS) * IW + ((x - px) >> SS) : 0;
  endfunction

  function automatic int addr_fs(input int x, input int y, input int fr, output bit inb);
    inb = (x < 640) && (y < 480);
    return inb ? fr * FSZ + ((y * IH) / 480) * IW + (x * IW) / 640 : 0;
  endfunction

  task automatic anim_tick();
    if (m_pend) begin
      m_t = 0; m_done = 1'b0; m_pend = 1'b0;
    end else if (m_en && !(m_done && !m_loop)) begin
      m_t++;
      if (m_t == NF * FH) begin
        if (m_loop) begin m_t = 0; m_done = 1'b0; end
        else        begin m_t = (NF - 1) * FH; m_done = 1'b1; end
      end
    end
  endtask

  // One pixel cycle: drive inputs on the falling edge and record what the model expects
  task automatic cyc(input int x, input int y, input bit bl, input bit rst);
    bit   inb_p, inb_f;
    int   a;
    logic [3:0] idx;
    @(negedge clk);
    reset = rst; draw_x = 10'(x); draw_y = 10'(y); blank = bl;
    pos_x = 10'(m_px); pos_y = 10'(m_py);
    anim_en = m_en; anim_loop = m_loop; anim_restart = m_rr;
    if (rst) begin
      m_t = 0; m_done = 1'b0; m_pend = 1'b0;
      e_p_addr = 0; e_f_addr = 0;
      qp.delete(); qf.delete();
      repeat (3) begin qp.push_back('0); qf.push_back('0); end
    end else begin
      m_pend = m_pend | m_rr;
      if (x == 0 && y == 0) anim_tick();
      a = addr_pos(x, y, m_px, m_py, m_t / FH, inb_p);
      e_p_addr = a;
      idx = rom_fn(a);
      qp.push_back((bl && inb_p && idx != 4'd0) ? pix_t'({1'b1, pal(idx)}) : pix_t'('0));
      a = addr_fs(x, y, m_t / FH, inb_f);
      e_f_addr = a;
      idx = rom_fn(a);
      qf.push_back((bl && inb_f) ? pix_t'({1'b1, pal(idx)}) : pix_t'('0));
    end
    e_frame = m_t / FH;
    e_done  = m_done;
    chk_on  = 1'b1;
  endtask

  // Compare every cycle: registered address/animation state after this edge, colour 3 edges later
  always @(posedge clk) begin
    if (chk_on) begin
      pix_t e;
      #1;
      chk("p_rom_address", 32'(p_addr), 32'(e_p_addr));
      chk("f_rom_address", 32'(f_addr), 32'(e_f_addr));
      chk("p_anim_frame", 32'(p_frame), 32'(e_frame));
      chk("f_anim_frame", 32'(f_frame), 32'(e_frame));
      chk("p_anim_done", 32'(p_done), 32'(e_done));
      chk("f_anim_done", 32'(f_done), 32'(e_done));
      if (qp.size() == 3) begin
        e = qp.pop_front();
        chk("p_pixel", 32'({p_hit, p_r, p_g, p_b}), 32'(e));
      end
      if (qf.size() == 3) begin
        e = qf.pop_front();
        chk("f_pixel", 32'({f_hit, f_r, f_g, f_b}), 32'(e));
      end
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  function automatic int near(input int base, input int span);
    int v;
    v = base + int'($urandom_range(0, span)) - 10;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  int seq_loop[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    int x, y;
    bit bl, rst;

    // Reset with pixels streaming, then first colour exactly 3 edges after release
    repeat (5) cyc(320, 240, 1'b1, 1'b1);
    after_edge();
    chk("rst_rgb", 32'({f_r, f_g, f_b, f_hit}), 0);
    chk("rst_frame", 32'(p_frame), 0);
    cyc(320, 240, 1'b1, 1'b0); after_edge(); chk("rel_hit1", 32'(f_hit), 0);
    cyc(320, 240, 1'b1, 1'b0); after_edge(); chk("rel_hit2", 32'(f_hit), 0);
    cyc(320, 240, 1'b1, 1'b0); after_edge(); chk("rel_hit3", 32'(f_hit), 1);

    // Positioned addressing at pos=(100,50), scale 2, frame 0
    cyc(100, 50, 1'b1, 1'b0); after_edge(); chk("addr_100_50", 32'(p_addr), 0);
    cyc(101, 50, 1'b1, 1'b0); after_edge(); chk("addr_101_50", 32'(p_addr), 0);
    cyc(102, 50, 1'b1, 1'b0); after_edge(); chk("addr_102_50", 32'(p_addr), 1);
    cyc(100, 52, 1'b1, 1'b0); after_edge(); chk("addr_100_52", 32'(p_addr), 110);
    cyc(639, 479, 1'b1, 1'b0); after_edge(); chk("fs_addr_corner", 32'(f_addr), 9459);
    repeat (3) cyc(320, 50, 1'b1, 1'b0);
    after_edge(); chk("hit_right_of_box", 32'(p_hit), 0);

    // Looping animation over 9 frame_starts
    m_loop = 1'b1;
    cyc(5, 5, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) cyc(0, 0, 1'b1, 1'b0);
      else       cyc(5, 5, 1'b1, 1'b0);
      after_edge();
      chk("loop_seq", 32'(p_frame), 32'(seq_loop[k]));
      cyc(150, 80, 1'b1, 1'b0);
    end

    // Non-looping: parks on frame 3 with anim_done
    m_loop = 1'b0;
    cyc(5, 5, 1'b1, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 0, 1'b1, 1'b0);
      after_edge();
      if (k == 7) chk("noloop_done7", 32'({p_done, p_frame}), 32'({1'b0, 2'd3}));
      if (k == 8) chk("noloop_done8", 32'({p_done, p_frame}), 32'({1'b1, 2'd3}));
      cyc(200, 100, 1'b1, 1'b0);
    end

    // Restart mid-frame at frame 2 on the frame_start that would otherwise advance
    m_loop = 1'b1;
    cyc(5, 5, 1'b1, 1'b1);
    repeat (5) begin cyc(0, 0, 1'b1, 1'b0); cyc(30, 30, 1'b1, 1'b0); end
    m_rr = 1'b1;
    cyc(300, 200, 1'b1, 1'b0);
    m_rr = 1'b0;
    after_edge(); chk("restart_pending", 32'(p_frame), 2);
    cyc(10, 10, 1'b1, 1'b0); after_edge(); chk("restart_pending2", 32'(p_frame), 2);
    cyc(0, 0, 1'b1, 1'b0); after_edge();
    chk("restart_frame", 32'(p_frame), 0);
    chk("restart_done", 32'(p_done), 0);
    chk("restart_base", 32'(f_addr), 0);

    // Randomised phase against the model
    for (int n = 0; n < 20000; n++) begin
      if (n % 1500 == 0) begin
        case ($urandom_range(0, 3))
          0: begin m_px = $urandom_range(0, 500);  m_py = $urandom_range(0, 300); end
          1: begin m_px = $urandom_range(560, 639); m_py = $urandom_range(420, 479); end
          2: begin m_px = $urandom_range(900, 1023); m_py = $urandom_range(900, 1023); end
          default: begin m_px = 0; m_py = 0; end
        endcase
        m_loop = $urandom_range(0, 1) != 0;
      end
      if ($urandom_range(0, 400) == 0) m_loop = ~m_loop;
      m_en = $urandom_range(0, 9) != 0;
      m_rr = $urandom_range(0, 299) == 0;
      rst  = $urandom_range(0, 2999) == 0;
      bl   = $urandom_range(0, 99) < 85;
      if ($urandom_range(0, 39) == 0) begin
        x = 0; y = 0;
      end else if ($urandom_range(0, 1) != 0) begin
        x = near(m_px, 240); y = near(m_py, 190);
      end else begin
        x = $urandom_range(0, 799); y = $urandom_range(0, 524);
      end
      cyc(x, y, bl, rst);
    end
    m_rr = 1'b0;
    repeat (4) cyc(700, 500, 1'b0, 1'b0);
    after_edge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
